l1_cache: RTL and testbench
===========================

L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 Parameter S_INDEX, default 3, means set-index width (2**S_INDEX sets, direct-mapped).
REQ-002 Parameter S_OFFSET, default 5, means byte-offset width (32-byte, 256-bit lines; fixed at 5).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mem_read  in  1  CPU read request, held until mem_resp.
REQ-006 mem_write  in  1  CPU write request, held until mem_resp.
REQ-007 mem_address  in  32  CPU byte address; [1:0] ignored.
REQ-008 mem_wdata  in  32  CPU store data, word-aligned lanes.
REQ-009 mem_byte_enable  in  4  store lane enables; bit i covers mem_wdata[8i+7:8i].
REQ-010 mem_rdata  out  32  read data, valid while mem_resp=1.
REQ-011 mem_resp  out  1  one-cycle completion pulse.
REQ-012 pmem_read  out  1  line-fill request to the memory side.
REQ-013 pmem_write  out  1  line-writeback request to the memory side.
REQ-014 pmem_address  out  32  line address, [4:0]=0.
REQ-015 pmem_wdata  out  256  writeback line.
REQ-016 pmem_rdata  in  256  fill line, valid with pmem_resp.
REQ-017 pmem_resp  in  1  memory-side completion pulse.

Function
REQ-018 Address split SHALL be tag=[31:8], index=[7:5], word=[4:2] at defaults; per set store valid, dirty, 24-bit tag, 256-bit data.
REQ-019 FSM states SHALL be IDLE, RESPOND, WRITEBACK, FILL.
REQ-020 IDLE: on request with valid and tag match (hit) SHALL go to RESPOND; on miss with valid and dirty SHALL go to WRITEBACK; on other miss SHALL go to FILL.
REQ-021 RESPOND SHALL assert mem_resp for exactly one cycle, then return to IDLE; hit latency SHALL be request-to-mem_resp of 1 cycle.
REQ-022 Read hit: mem_rdata SHALL equal data[index] word [word] during the mem_resp cycle.
REQ-023 Write hit: on the RESPOND edge, each enabled byte SHALL be merged into data[index] word [word]; dirty SHALL be set only if mem_byte_enable != 0; disabled bytes SHALL be unchanged.
REQ-024 WRITEBACK SHALL hold pmem_write=1, pmem_address={stored tag, index, 5'b0}, pmem_wdata=stored line until pmem_resp, then clear dirty and go to FILL.
REQ-025 FILL SHALL hold pmem_read=1, pmem_address={mem_address[31:5], 5'b0} until pmem_resp; on that edge it SHALL write pmem_rdata into the set, set valid, clear dirty, load tag, and go to IDLE (request re-evaluates as a hit).
REQ-026 pmem_read and pmem_write SHALL never be asserted simultaneously; both SHALL be 0 outside FILL/WRITEBACK.
REQ-027 mem_read and mem_write both asserted SHALL be treated as a write.
REQ-028 No request in IDLE SHALL leave state, arrays and outputs unchanged.
REQ-029 pmem_resp outside FILL/WRITEBACK SHALL be ignored.
REQ-030 Miss latency SHALL be (clean) fill-wait + 2 cycles and (dirty) writeback-wait + fill-wait + 2 cycles beyond the pmem_resp cycles.

Reset
REQ-031 rst=0 SHALL asynchronously force state IDLE, all valid and dirty bits 0, mem_resp, pmem_read, pmem_write 0; data and tag arrays need not be reset.
REQ-032 rst asserted mid-WRITEBACK or mid-FILL SHALL abort the transfer immediately with no array update; the first request after rst release SHALL miss.

Verification
REQ-033 After reset, read 0x0000_0104 -> FILL with pmem_address 0x0000_0100; pmem_rdata word1=0xDEAD_BEEF -> mem_resp with mem_rdata 0xDEAD_BEEF two cycles after pmem_resp.
REQ-034 Read 0x0000_0104 again -> mem_resp exactly 1 cycle after request, pmem_read never asserted.
REQ-035 Write 0x0000_0104, wdata 0x1122_3344, byte_enable 4'b0011 -> hit, subsequent read returns 0xDEAD_3344, set dirty.
REQ-036 Read 0x0000_1104 (same index, new tag) -> pmem_write with address 0x0000_0100 and pmem_wdata word1 0xDEAD_3344, then pmem_read at 0x0000_1100, then mem_resp.
REQ-037 Write with byte_enable 4'b0000 on a clean hit -> mem_resp, line unchanged, later eviction performs no WRITEBACK.
REQ-038 Drop rst during FILL with pmem_resp pending -> pmem_read deasserts same cycle, mem_resp stays 0, re-read after release misses again.

Source files
------------

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with a 32-bit CPU port and a
// 256-bit line port to memory. One outstanding request; the CPU holds it until mem_resp.
module l1_cache #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [1:0]   dbg_state_o
);

    localparam int SETS   = 1 << S_INDEX;
    localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
    localparam int WORD_W = S_OFFSET - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESPOND   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]  valid_q, valid_d;
    logic [SETS-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [255:0]     data_q [SETS];

    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [WORD_W-1:0]  req_word;
    logic               req_valid;
    logic               hit;
    logic [255:0]       cur_line;
    logic [255:0]       merged_line;
    logic [255:0]       line_wdata;
    logic               line_we;
    logic               tag_we;
    logic               unused_addr_lsbs;

    assign req_tag          = mem_address[31 -: TAG_W];
    assign req_idx          = mem_address[S_OFFSET +: S_INDEX];
    assign req_word         = mem_address[2 +: WORD_W];
    assign req_valid        = mem_read | mem_write;
    assign unused_addr_lsbs = ^mem_address[1:0];

    assign cur_line    = data_q[req_idx];
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign mem_rdata   = cur_line[32*req_word +: 32];
    assign pmem_wdata  = cur_line;
    assign dbg_state_o = state_q;

    // Store data merged byte-by-byte into the addressed word of the current line.
    always_comb begin
        merged_line = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                merged_line[32*req_word + 8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        line_we      = 1'b0;
        line_wdata   = merged_line;
        tag_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (hit) begin
                        state_d = RESPOND;
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            RESPOND: begin
                mem_resp = 1'b1;
                state_d  = IDLE;
                // A write with no lanes enabled completes but must not dirty the line.
                if (mem_write) begin
                    line_we = 1'b1;
                    if (|mem_byte_enable) begin
                        dirty_d[req_idx] = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[req_idx], req_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    dirty_d[req_idx] = 1'b0;
                    state_d          = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    line_we          = 1'b1;
                    line_wdata       = pmem_rdata;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Line storage is not reset; writes are gated by FSM states that reset cannot reach.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[req_idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache: directed scenarios then random traffic, checked against a flat
// memory image plus a per-set residency model; the bench also plays the memory side.
module tb_l1_cache;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   dbg_state;

    logic resp_drv;
    logic stray_resp;
    logic resp_en;
    assign pmem_resp = resp_drv | stray_resp;

    int n_tests;
    int n_fail;
    int wait_cnt;

    logic [31:0]  exp_q[$];
    logic [31:0]  fill_q[$];
    logic [31:0]  wb_addr_q[$];
    logic [255:0] wb_data_q[$];

    logic [255:0] bmem [int unsigned];
    logic [31:0]  gold [int unsigned];

    logic        ref_valid [8];
    logic        ref_dirty [8];
    logic [23:0] ref_tag   [8];
    logic [31:0] last_rdata;

    l1_cache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .dbg_state_o     (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void set_line(input int unsigned line, input logic [255:0] data);
        bmem[line] = data;
        for (int w = 0; w < 8; w++) gold[line*8 + w] = data[32*w +: 32];
    endfunction

    function automatic void touch(input int unsigned line);
        logic [255:0] l;
        if (!bmem.exists(line)) begin
            for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
            set_line(line, l);
        end
    endfunction

    function automatic logic [255:0] gold_line(input int unsigned line);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = gold[line*8 + w];
        return r;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            ref_valid[s] = 1'b0;
            ref_dirty[s] = 1'b0;
            ref_tag[s]   = '0;
        end
        // Anything not yet written back is lost: memory image reverts to backing store.
        foreach (bmem[k]) set_line(k, bmem[k]);
    endfunction

    // memory-side responder
    initial begin
        resp_drv   = 1'b0;
        pmem_rdata = '0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_drv = 1'b0;
            if (resp_en && (pmem_read || pmem_write)) begin
                if (wait_cnt == 0) begin
                    resp_drv = 1'b1;
                    if (pmem_read) begin
                        fill_q.push_back(pmem_address);
                        pmem_rdata = bmem[int'(pmem_address[31:5])];
                    end else begin
                        wb_addr_q.push_back(pmem_address);
                        wb_data_q.push_back(pmem_wdata);
                        bmem[int'(pmem_address[31:5])] = pmem_wdata;
                    end
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be);
        int unsigned line;
        int          s;
        logic        hit;
        logic        wb_exp;
        logic [31:0] wb_addr_exp;
        logic [255:0] wb_data_exp;
        logic [31:0] w;
        int          cyc;
        int          fill_cyc;
        int          overlap;
        int          pread_cyc;
        logic        got;
        logic [31:0] rdata;

        line = int'(addr[31:5]);
        s    = int'(addr[7:5]);
        touch(line);
        hit         = ref_valid[s] && (ref_tag[s] == addr[31:8]);
        wb_exp      = !hit && ref_valid[s] && ref_dirty[s];
        wb_addr_exp = {ref_tag[s], 3'(s), 5'd0};
        wb_data_exp = gold_line(int'({ref_tag[s], 3'(s)}));
        if (rd && !wr) exp_q.push_back(gold[int'(addr[31:2])]);

        fill_q.delete();
        wb_addr_q.delete();
        wb_data_q.delete();

        @(posedge clk);
        #1;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wd;
        mem_byte_enable = be;

        cyc       = 0;
        fill_cyc  = -1;
        overlap   = 0;
        pread_cyc = 0;
        got       = 1'b0;
        rdata     = '0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (pmem_read && pmem_write) overlap++;
            if (pmem_read) pread_cyc++;
            if (pmem_read && pmem_resp) fill_cyc = cyc;
            if (mem_resp) begin
                got   = 1'b1;
                rdata = mem_rdata;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        last_rdata = rdata;

        check_val("resp_seen", got, 1'b1);
        if (rd && !wr && exp_q.size() > 0) check_val("rdata", rdata, exp_q.pop_front());
        exp_q.delete();
        check_val("n_wb", wb_addr_q.size(), wb_exp);
        if (wb_exp && wb_addr_q.size() > 0) begin
            check_val("wb_addr", wb_addr_q[0], wb_addr_exp);
            check_val("wb_data", wb_data_q[0], wb_data_exp);
        end
        check_val("n_fill", fill_q.size(), !hit);
        if (!hit && fill_q.size() > 0) check_val("fill_addr", fill_q[0], {addr[31:5], 5'd0});
        if (hit) begin
            check_val("hit_lat", cyc, 1);
            check_val("hit_no_pread", pread_cyc, 0);
        end else begin
            check_val("miss_lat", cyc, fill_cyc + 2);
        end
        check_val("pmem_excl", overlap, 0);

        if (!hit) begin
            ref_valid[s] = 1'b1;
            ref_tag[s]   = addr[31:8];
            ref_dirty[s] = 1'b0;
        end
        if (wr) begin
            if (be != 4'b0) ref_dirty[s] = 1'b1;
            w = gold[int'(addr[31:2])];
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            gold[int'(addr[31:2])] = w;
        end
    endtask

    initial begin
        logic [255:0] l;
        logic [255:0] wbd;
        logic [31:0]  addr;
        int           kind;
        int           n;

        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        stray_resp      = 1'b0;
        resp_en         = 1'b1;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_mem_resp", mem_resp, 1'b0);
        check_val("rst_pmem_read", pmem_read, 1'b0);
        check_val("rst_pmem_write", pmem_write, 1'b0);
        check_val("rst_state", dbg_state, 2'd0);
        rst = 1'b1;

        // cold miss, then hit
        for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
        l[63:32] = 32'hDEADBEEF;
        set_line(32'h8, l);
        do_access(1'b1, 1'b0, 32'h0000_0104, '0, 4'h0);
        check_val("rd_deadbeef", last_rdata, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h0000_0104, '0, 4'h0);

        // partial write hit, then read back
        do_access(1'b0, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0011);
        do_access(1'b1, 1'b0, 32'h0000_0104, '0, 4'h0);
        check_val("rd_dead3344", last_rdata, 32'hDEAD3344);

        // dirty eviction
        do_access(1'b1, 1'b0, 32'h0000_1104, '0, 4'h0);
        wbd = (wb_data_q.size() > 0) ? wb_data_q[0] : '0;
        check_val("wb_word1", wbd[63:32], 32'hDEAD3344);

        // zero-enable write keeps the line clean
        do_access(1'b0, 1'b1, 32'h0000_1104, 32'hFFFF_FFFF, 4'b0000);
        do_access(1'b1, 1'b0, 32'h0000_2104, '0, 4'h0);
        check_val("be0_no_wb", wb_addr_q.size(), 0);

        // reset during a fill with the memory response pending
        resp_en = 1'b0;
        touch(32'h3104 >> 5);
        @(posedge clk);
        #1;
        mem_read    = 1'b1;
        mem_address = 32'h0000_3104;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_read && n < 10);
        check_val("abort_fill_start", pmem_read, 1'b1);
        #1;
        stray_resp = 1'b1;
        rst        = 1'b0;
        #1;
        check_val("abort_pread", pmem_read, 1'b0);
        check_val("abort_pwrite", pmem_write, 1'b0);
        check_val("abort_resp", mem_resp, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check_val("abort_resp_hold", mem_resp, 1'b0);
        end
        mem_read   = 1'b0;
        stray_resp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // stray memory response while idle
        @(posedge clk);
        #1;
        stray_resp = 1'b1;
        @(posedge clk);
        #1;
        stray_resp = 1'b0;
        @(negedge clk);
        check_val("stray_state", dbg_state, 2'd0);
        check_val("stray_resp", mem_resp, 1'b0);
        resp_en = 1'b1;

        do_access(1'b1, 1'b0, 32'h0000_3104, '0, 4'h0);
        do_access(1'b1, 1'b0, 32'h0000_0104, '0, 4'h0);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            addr = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 2'($urandom)};
            kind = $urandom_range(0, 9);
            if (kind < 5) do_access(1'b1, 1'b0, addr, $urandom, 4'($urandom));
            else if (kind < 9) do_access(1'b0, 1'b1, addr, $urandom, 4'($urandom));
            else do_access(1'b1, 1'b1, addr, $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
